// File: rtl/spart_fifo.sv
// SPART: byte-wide bus UART with TX/RX FIFOs, a programmable 16-bit baud divisor and optional parity.
// The register file sits on a shared tri-state bus.
`timescale 1ns/1ps

module spart_fifo_buf #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // An extra wrap bit on each pointer tells full from empty.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
        rdata   = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
endmodule

module spart_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PARITY     = 0,
    parameter logic [15:0] DIV_RST    = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    localparam int unsigned BW       = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic [15:0]       div_q, div_d;
    state_e            tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0]       tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
    logic [15:0]       rx_cnt_q, rx_cnt_d, rx_bdiv_q, rx_bdiv_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic              tx_par_q, tx_par_d, txd_q, txd_d, rx_perr_q, rx_perr_d;
    logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic              ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;

    logic              tx_push, tx_pop, tx_empty, tx_full, tx_tick, tx_load;
    logic              rx_push, rx_pop, rx_empty, rx_full, rx_tick, flag_clr;
    logic [DATA_W-1:0] tx_head, rx_head, tx_wdata;
    logic [15:0]       rx_half_c;
    logic [7:0]        rd_data_c;
    logic              tx_idle_c;

    spart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(tx_wdata),
        .rdata(tx_head), .empty(tx_empty), .full(tx_full));

    spart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_sh_q),
        .rdata(rx_head), .empty(rx_empty), .full(rx_full));

    assign databus = (iocs & iorw) ? rd_data_c : 8'bz;
    assign rda     = ~rx_empty;
    assign tbr     = ~tx_full;
    assign txd     = txd_q;

    // Bus decode: combinational read mux, FIFO push/pop and divisor writes.
    always_comb begin
        tx_idle_c = (tx_state_q == S_IDLE) && tx_empty;
        rd_data_c = 8'h00;
        case (ioaddr)
            2'b00:   rd_data_c = rx_empty ? 8'h00 : 8'(rx_head);
            2'b01:   rd_data_c = {2'b00, tx_idle_c, perr_q, ferr_q, ovr_q, ~tx_full, ~rx_empty};
            2'b10:   rd_data_c = div_q[7:0];
            default: rd_data_c = div_q[15:8];
        endcase
        rx_pop   = iocs & iorw & (ioaddr == 2'b00) & ~rx_empty;
        tx_push  = iocs & ~iorw & (ioaddr == 2'b00);
        tx_wdata = databus[DATA_W-1:0];
        flag_clr = iocs & ~iorw & (ioaddr == 2'b01);
        div_d    = div_q;
        if (iocs & ~iorw & (ioaddr == 2'b10)) div_d[7:0]  = databus;
        if (iocs & ~iorw & (ioaddr == 2'b11)) div_d[15:8] = databus;
    end

    // Transmitter: divisor is re-latched only at bit boundaries.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bdiv_d  = tx_bdiv_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        tx_tick    = (tx_cnt_q == tx_bdiv_q);
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d  = '0;
                tx_bdiv_d = div_q;
                txd_d     = 1'b1;
                tx_load   = ~tx_empty;
            end
            S_START: if (tx_tick) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
                txd_d      = tx_sh_q[0];
            end
            S_DATA: if (tx_tick) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + BIT_ONE;
                if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = PAR_EN ? S_PAR : S_STOP;
                    txd_d      = PAR_EN ? tx_par_q : 1'b1;
                end else begin
                    txd_d = tx_sh_q[1];
                end
            end
            S_PAR: if (tx_tick) begin
                tx_state_d = S_STOP;
                txd_d      = 1'b1;
            end
            S_STOP: if (tx_tick) begin
                tx_load    = ~tx_empty;
                tx_state_d = S_IDLE;
                txd_d      = 1'b1;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_tick && tx_state_q != S_IDLE) begin
            tx_cnt_d  = '0;
            tx_bdiv_d = div_q;
        end
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_state_d = S_START;
            txd_d      = 1'b0;
            tx_cnt_d   = '0;
            tx_bdiv_d  = div_q;
        end
    end

    // Receiver: falling edge arms, half-period start check, then full-period samples.
    always_comb begin
        rx_s1_d    = rxd;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bdiv_d  = rx_bdiv_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        rx_tick    = (rx_cnt_q == rx_bdiv_q);
        rx_half_c  = 16'((17'(rx_bdiv_q) + 17'd1) >> 1);
        ovr_d      = ovr_q  & ~(flag_clr & databus[2]);
        ferr_d     = ferr_q & ~(flag_clr & databus[3]);
        perr_d     = perr_q & ~(flag_clr & databus[4]);
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d  = '0;
                rx_bdiv_d = div_q;
                if (rx_prev_q & ~rx_s2_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == rx_half_c) begin
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                rx_cnt_d   = '0;
                rx_bdiv_d  = div_q;
                rx_bit_d   = '0;
                rx_perr_d  = 1'b0;
            end
            S_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
                rx_bit_d = rx_bit_q + BIT_ONE;
                if (rx_bit_q == LAST_BIT) rx_state_d = PAR_EN ? S_PAR : S_STOP;
            end
            S_PAR: if (rx_tick) begin
                rx_perr_d  = (^rx_sh_q) ^ rx_s2_q ^ PAR_ODD;
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_tick) begin
                rx_state_d = S_IDLE;
                if (!rx_s2_q)      ferr_d  = 1'b1;
                else if (rx_perr_q) perr_d = 1'b1;
                else if (rx_full)  ovr_d   = 1'b1;
                else               rx_push = 1'b1;
            end
            default: rx_state_d = S_IDLE;
        endcase
        if (rx_tick && (rx_state_q == S_DATA || rx_state_q == S_PAR)) begin
            rx_cnt_d  = '0;
            rx_bdiv_d = div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_RST;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bdiv_q  <= DIV_RST;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bdiv_q  <= DIV_RST;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_perr_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bdiv_q  <= tx_bdiv_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bdiv_q  <= rx_bdiv_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_perr_q  <= rx_perr_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end
endmodule

// File: tb/tb_spart_fifo.sv
// Directed bench for spart_fifo: one no-parity instance (also looped back) and one even-parity instance.
`timescale 1ns/1ps

module tb_spart_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs0 = 1'b0, cs1 = 1'b0, rw = 1'b0, en0 = 1'b0, en1 = 1'b0;
    logic [1:0] addr = 2'b00;
    logic [7:0] drv = 8'h00;
    logic       rxd0_drv = 1'b1, rxd1 = 1'b1, loop = 1'b0;
    wire  [7:0] db0, db1;
    logic       rda0, tbr0, txd0, rda1, tbr1, txd1;
    logic       rxd0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign rxd0 = loop ? txd0 : rxd0_drv;
    assign db0  = en0 ? drv : 8'bz;
    assign db1  = en1 ? drv : 8'bz;

    spart_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .PARITY(0), .DIV_RST(16'd325)) dut0 (
        .clk(clk), .rst(rst), .iocs(cs0), .iorw(rw), .ioaddr(addr), .databus(db0),
        .rda(rda0), .tbr(tbr0), .txd(txd0), .rxd(rxd0));

    spart_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .PARITY(1), .DIV_RST(16'd325)) dut1 (
        .clk(clk), .rst(rst), .iocs(cs1), .iorw(rw), .ioaddr(addr), .databus(db1),
        .rda(rda1), .tbr(tbr1), .txd(txd1), .rxd(rxd1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input int sel, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        rw = 1'b0; addr = a; drv = d;
        if (sel == 0) begin cs0 = 1'b1; en0 = 1'b1; end
        else          begin cs1 = 1'b1; en1 = 1'b1; end
        @(posedge clk); #1;
        cs0 = 1'b0; cs1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
    endtask

    task automatic bus_rd(input int sel, input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        rw = 1'b1; addr = a;
        if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
        #1;
        d = (sel == 0) ? db0 : db1;
        @(posedge clk); #1;
        cs0 = 1'b0; cs1 = 1'b0;
    endtask

    task automatic rx_cell(input int sel, input logic v);
        if (sel == 0) rxd0_drv = v; else rxd1 = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input int sel, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stop);
        rx_cell(sel, 1'b0);
        for (int i = 0; i < 8; i++) rx_cell(sel, d[i]);
        if (use_par) rx_cell(sel, pbit);
        rx_cell(sel, stop);
        rx_cell(sel, 1'b1);
        rx_cell(sel, 1'b1);
    endtask

    // Waits (bounded) for the start bit on dut0 txd; returns at posedge+1 of its first cycle.
    task automatic wait_tx_start(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk); #1;
            if (txd0 == 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_bits;
        logic       seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rda", 8'(rda0), 8'h00);
        chk("rst_tbr", 8'(tbr0), 8'h01);
        chk("rst_txd", 8'(txd0), 8'h01);
        bus_rd(0, 2'b01, rd); chk("rst_status", rd, 8'h22);
        bus_rd(0, 2'b10, rd); chk("rst_div_lo", rd, 8'h45);
        bus_rd(0, 2'b11, rd); chk("rst_div_hi", rd, 8'h01);
        bus_rd(0, 2'b00, rd); chk("empty_read", rd, 8'h00);

        // Divisor 3 on both instances -> 4 clocks per bit
        bus_wr(0, 2'b10, 8'h03); bus_wr(0, 2'b11, 8'h00);
        bus_wr(1, 2'b10, 8'h03); bus_wr(1, 2'b11, 8'h00);
        bus_rd(0, 2'b10, rd); chk("div_lo", rd, 8'h03);
        bus_rd(0, 2'b11, rd); chk("div_hi", rd, 8'h00);

        // TX 0x55 bit-exact waveform
        bus_wr(0, 2'b00, 8'h55);
        wait_tx_start(seen);
        chk("tx55_start_seen", 8'(seen), 8'h01);
        exp_bits = 8'h55;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (b == 0)      chk("tx55_start", 8'(txd0), 8'h00);
                else if (b == 9) chk("tx55_stop", 8'(txd0), 8'h01);
                else             chk("tx55_data", 8'(txd0), 8'(exp_bits[b-1]));
                @(posedge clk); #1;
            end
        end
        bus_rd(0, 2'b01, rd); chk("tx55_idle_status", rd, 8'h22);

        // Loopback, three back-to-back frames
        loop = 1'b1;
        bus_wr(0, 2'b00, 8'hA3);
        bus_wr(0, 2'b00, 8'h00);
        bus_wr(0, 2'b00, 8'hFF);
        repeat (160) @(posedge clk);
        #1;
        chk("loop_rda", 8'(rda0), 8'h01);
        bus_rd(0, 2'b00, rd); chk("loop_rd0", rd, 8'hA3);
        bus_rd(0, 2'b00, rd); chk("loop_rd1", rd, 8'h00);
        chk("loop_rda_mid", 8'(rda0), 8'h01);
        bus_rd(0, 2'b00, rd); chk("loop_rd2", rd, 8'hFF);
        chk("loop_rda_fall", 8'(rda0), 8'h00);
        bus_rd(0, 2'b01, rd); chk("loop_status", rd, 8'h22);
        loop = 1'b0;

        // Overrun: 9 frames into an 8-deep RX FIFO
        for (int f = 0; f < 9; f++) rx_frame(0, 8'(8'h10 + f), 1'b0, 1'b0, 1'b1);
        chk("ovr_rda", 8'(rda0), 8'h01);
        bus_rd(0, 2'b01, rd); chk("ovr_status", rd, 8'h27);
        for (int f = 0; f < 8; f++) begin
            bus_rd(0, 2'b00, rd); chk("ovr_data", rd, 8'(8'h10 + f));
        end
        bus_wr(0, 2'b01, 8'h04);
        bus_rd(0, 2'b01, rd); chk("ovr_clear", rd, 8'h22);

        // Framing error, then a one-cycle glitch
        rx_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        bus_rd(0, 2'b01, rd); chk("ferr_status", rd, 8'h2A);
        chk("ferr_no_push", 8'(rda0), 8'h00);
        bus_wr(0, 2'b01, 8'h08);
        bus_rd(0, 2'b01, rd); chk("ferr_clear", rd, 8'h22);
        rxd0_drv = 1'b0;
        @(posedge clk); #1;
        rxd0_drv = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_rda", 8'(rda0), 8'h00);
        bus_rd(0, 2'b01, rd); chk("glitch_status", rd, 8'h22);

        // Even parity instance: bad then good parity on 0x07
        rx_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        bus_rd(1, 2'b01, rd); chk("perr_status", rd, 8'h32);
        chk("perr_no_push", 8'(rda1), 8'h00);
        bus_wr(1, 2'b01, 8'h10);
        rx_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        chk("par_ok_rda", 8'(rda1), 8'h01);
        bus_rd(1, 2'b00, rd); chk("par_ok_data", rd, 8'h07);
        bus_rd(1, 2'b01, rd); chk("par_ok_status", rd, 8'h22);

        // Reset mid-frame during data bit 4 of 0xC3
        bus_wr(0, 2'b00, 8'hC3);
        wait_tx_start(seen);
        chk("c3_start_seen", 8'(seen), 8'h01);
        repeat (21) @(posedge clk);
        #1;
        chk("c3_bit4", 8'(txd0), 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_txd", 8'(txd0), 8'h01);
        chk("midrst_tbr", 8'(tbr0), 8'h01);
        chk("midrst_rda", 8'(rda0), 8'h00);
        rst = 1'b0;
        bus_rd(0, 2'b01, rd); chk("midrst_status", rd, 8'h22);
        bus_rd(0, 2'b10, rd); chk("midrst_div_lo", rd, 8'h45);
        repeat (60) @(posedge clk);
        #1;
        chk("midrst_txd_quiet", 8'(txd0), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spart_fifo.md
SPART_FIFO -- requirements
Module: spart_fifo

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning frame data bits; legal range 5..8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning entries per TX and per RX FIFO; power of 2, >=2.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter DIV_RST, default 16'd325, meaning the reset value of the baud divisor.
REQ-006 The block SHALL have the port clk  input  1  system clock.
REQ-007 The block SHALL have the port rst  input  1  synchronous active-high reset.
REQ-008 The block SHALL have the port iocs  input  1  chip select; each cycle it is high is one bus access.
REQ-009 The block SHALL have the port iorw  input  1  1 = read (block drives databus), 0 = write.
REQ-010 The block SHALL have the port ioaddr  input  2  00 data FIFO, 01 status, 10 divisor low, 11 divisor high.
REQ-011 The block SHALL have the port databus  inout  8  bidirectional bus, high-Z unless iocs & iorw.
REQ-012 The block SHALL have the port rda  output  1  RX FIFO not empty.
REQ-013 The block SHALL have the port tbr  output  1  TX FIFO not full.
REQ-014 The block SHALL have the port txd  output  1  serial out, idle high.
REQ-015 The block SHALL have the port rxd  input  1  serial in, asynchronous, idle high.

Function
REQ-016 Bit period SHALL be divisor+1 clk cycles; divisor is 16 bits, built from ioaddr 10 (low) and 11 (high) writes.
REQ-017 Divisor writes SHALL take effect at the next bit boundary, never mid-bit.
REQ-018 Write to 00 SHALL push databus[DATA_W-1:0] into TX FIFO; a write when full SHALL be dropped without error.
REQ-019 Read of 00 SHALL drive the RX FIFO head, zero-extended, combinationally and pop it at the clock edge; a read when empty SHALL return 0 with no pop.
REQ-020 Read of 01 SHALL return {2'b0, tx_idle, perr, ferr, ovr, tbr, rda}.
REQ-021 Write of 01 SHALL clear each sticky flag ovr/ferr/perr whose databus bit (2/3/4) is 1.
REQ-022 Reads of 10/11 SHALL return the divisor bytes.
REQ-023 Simultaneous engine push and bus pop on one FIFO SHALL both occur, leaving the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 TX FSM SHALL have states IDLE, START, DATA, PAR, STOP; IDLE->START when TX FIFO is non-empty, popping that cycle.
REQ-025 TX SHALL send start 0, DATA_W bits LSB first, a parity bit if PARITY!=0, then stop 1, each for one bit period; STOP->START back-to-back if the FIFO is non-empty, else IDLE.
REQ-026 tx_idle SHALL be 1 only in TX IDLE with the TX FIFO empty.
REQ-027 rxd SHALL pass a 2-flop synchroniser; RX FSM states are IDLE, START, DATA, PAR, STOP.
REQ-028 RX IDLE->START SHALL occur on a synchronised 1->0; START SHALL sample at (divisor+1)/2 cycles; a high sample returns to IDLE as a false start.
REQ-029 RX data, parity and stop SHALL be sampled at mid-bit, one bit period apart.
REQ-030 A stop sample of 0 SHALL set ferr and drop the frame; the FSM SHALL then wait for rxd high before re-arming.
REQ-031 A parity mismatch SHALL set perr and drop the frame.
REQ-032 A good frame with RX FIFO full SHALL set ovr and drop the frame; FIFO contents are unchanged.
REQ-033 ferr precedence SHALL be over perr when both occur.

Reset
REQ-034 On rst: both FIFOs empty, FSMs IDLE, divisor=DIV_RST, flags 0, txd=1, rda=0, tbr=1, databus high-Z.
REQ-035 rst asserted mid-frame SHALL abort the frame in the next cycle with txd=1 and no FIFO push.

Verification
REQ-036 Scenario: divisor=3, write 0x55 -> txd 0,1,0,1,0,1,0,1,0,1, each 4 clks, then tx_idle=1.
REQ-037 Scenario: loop txd->rxd, write 0xA3, 0x00, 0xFF back-to-back -> 3 reads return the same bytes in order; rda falls after the third.
REQ-038 Scenario: FIFO_DEPTH+1 received frames, no reads -> rda=1, ovr=1, reads return first FIFO_DEPTH bytes; write 0x04 to 01 -> ovr=0.
REQ-039 Scenario: rxd frame with stop=0 -> ferr=1, no push; 1-cycle low glitch on rxd -> no push, no flags.
REQ-040 Scenario: PARITY=1, rx 0x07 with parity 0 -> perr=1 and no push; with parity 1 -> byte pushed.
REQ-041 Scenario: rst pulse during TX bit 4 -> txd=1 next cycle, tbr=1, status reads 0x22.
